button_press_decoder: RTL and testbench

//   Converts the three raw front-panel buttons (INC, SET, SW) into the one-cycle,

---
 rtl/button_press_decoder.sv | 151 +++++++++++++++
 tb/tb_button_press_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_decoder.sv
// button_press_decoder
//   Turns the three raw front-panel buttons into one-cycle command pulses for
//   the mode FSM. Each button is synchronised (2 flops) and debounced. INC
//   presses are classified as short or long by hold time. Coincident events
//   are queued in pending bits and emitted one per cycle by fixed priority
//   (set > sw > inc_long > inc_short), so at most one output is high per cycle.
//
// Ports
//   clk          in   system clock, everything on posedge
//   rst          in   synchronous reset, active-high
//   btn_inc_raw  in   raw INC button (async, bouncing, 1 = pressed)
//   btn_set_raw  in   raw SET button (async, bouncing, 1 = pressed)
//   btn_sw_raw   in   raw SW button  (async, bouncing, 1 = pressed)
//   inc_short    out  pulse: INC released before LONG_CYC hold
//   inc_long     out  pulse: INC hold reached LONG_CYC
//   set          out  pulse: SET press accepted
//   sw           out  pulse: SW press accepted
module button_press_decoder #(
    parameter int unsigned DEBOUNCE_CYC = 500_000,
    parameter int unsigned LONG_CYC     = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc_raw,
    input  logic btn_set_raw,
    input  logic btn_sw_raw,
    output logic inc_short,
    output logic inc_long,
    output logic set,
    output logic sw
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } inc_state_e;

    // Button index: 0 = INC, 1 = SET, 2 = SW
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            stable_q, stable_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            accept;
    logic [2:0]            rise;
    logic                  inc_fall;

    inc_state_e            state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  ev_short, ev_long;

    // Pending / output bit order: 0 = set, 1 = sw, 2 = inc_long, 3 = inc_short
    logic [3:0]            events;
    logic [3:0]            pend_q, pend_d;
    logic [3:0]            grant;
    logic [3:0]            out_q;

    // Debounce: count consecutive cycles the synchronised level differs from the
    // stable level; accept the new level on the cycle the count is already full.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        accept   = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    stable_d[i] = sync2_q[i];
                    accept[i]   = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise     = accept & sync2_q;
    assign inc_fall = accept[0] & ~sync2_q[0];

    // INC classifier; reacts to the accept strobe so it lines up with SET/SW events.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ev_short = 1'b0;
        ev_long  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise[0]) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    ev_long = 1'b1;
                    hold_d  = '0;
                    // A release on the very same cycle must not strand us in WAIT_REL.
                    state_d = inc_fall ? IDLE : WAIT_REL;
                end else if (inc_fall) begin
                    ev_short = 1'b1;
                    hold_d   = '0;
                    state_d  = IDLE;
                end
            end
            WAIT_REL: begin
                if (inc_fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration: lowest set bit wins (x & -x). A new event for a source whose
    // pending bit is still set is dropped.
    assign events = {ev_short, ev_long, rise[2], rise[1]};
    assign grant  = pend_q & (~pend_q + 4'd1);
    assign pend_d = (pend_q & ~grant) | (events & ~pend_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            db_cnt_q <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            pend_q   <= '0;
            out_q    <= '0;
        end else begin
            sync1_q  <= {btn_sw_raw, btn_set_raw, btn_inc_raw};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            out_q    <= grant;
        end
    end

    assign set       = out_q[0];
    assign sw        = out_q[1];
    assign inc_long  = out_q[2];
    assign inc_short = out_q[3];

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder with DEBOUNCE_CYC=4, LONG_CYC=20.
// Reference model: a raw-sample history window per button (level accepted once
// the last D+1 synchronised samples all disagree with it), press timestamps for
// INC classification, and a priority queue of pending events.
module tb_button_press_decoder;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam logic [15:0] WIN = 16'h003E;  // history bits 1..D+1

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_inc_raw = 1'b1;
    logic btn_set_raw = 1'b1;
    logic btn_sw_raw  = 1'b1;
    logic inc_short, inc_long, set, sw;

    button_press_decoder #(
        .DEBOUNCE_CYC(D),
        .LONG_CYC(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_inc_raw(btn_inc_raw),
        .btn_set_raw(btn_set_raw),
        .btn_sw_raw(btn_sw_raw),
        .inc_short(inc_short),
        .inc_long(inc_long),
        .set(set),
        .sw(sw)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Model state; output order 0 = set, 1 = sw, 2 = inc_long, 3 = inc_short
    logic [15:0] hist [3];
    logic [2:0]  m_stable = '0;
    bit          press_on = 1'b0;
    int          press_edge = 0;
    logic [3:0]  pend = '0;
    logic [3:0]  exp_out = '0;

    int          pcount [4];
    int          plast  [4];

    always @(posedge clk) begin : model
        logic [2:0] raw_now;
        logic [2:0] m_rise, m_fall;
        logic [3:0] ev, old;
        int         age;
        cyc = cyc + 1;
        raw_now = {btn_sw_raw, btn_set_raw, btn_inc_raw};
        if (rst) begin
            for (int unsigned b = 0; b < 3; b++) hist[b] = '0;
            m_stable = '0;
            press_on = 1'b0;
            pend     = '0;
            exp_out  = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int unsigned b = 0; b < 3; b++) begin
                if ((hist[b] & WIN) == (m_stable[b] ? 16'h0000 : WIN)) begin
                    m_stable[b] = ~m_stable[b];
                    m_rise[b]   = m_stable[b];
                    m_fall[b]   = ~m_stable[b];
                end
            end
            ev = {2'b00, m_rise[2], m_rise[1]};
            if (m_rise[0]) begin
                press_on   = 1'b1;
                press_edge = cyc;
            end else if (press_on) begin
                age = cyc - press_edge;
                if (m_fall[0] && age < int'(L)) ev[3] = 1'b1;
                else if (age == int'(L)) ev[2] = 1'b1;
                if (m_fall[0] || age >= int'(L)) press_on = 1'b0;
            end
            old = pend;
            exp_out = '0;
            for (int unsigned k = 0; k < 4; k++) begin
                if (old[k]) begin
                    exp_out[k] = 1'b1;
                    pend[k]    = 1'b0;
                    break;
                end
            end
            for (int unsigned k = 0; k < 4; k++)
                if (ev[k] && !old[k]) pend[k] = 1'b1;
            for (int unsigned b = 0; b < 3; b++)
                hist[b] = {hist[b][14:0], raw_now[b]};
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] act;
        if (cyc > 0) begin
            act = {inc_short, inc_long, sw, set};
            checks++;
            if (act !== exp_out) begin
                errors++;
                $display("FAIL outputs cyc=%0d actual={short,long,sw,set}=%b required=%b",
                         cyc, act, exp_out);
            end
            checks++;
            if ($countones(act) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d actual=%b required=at most one bit", cyc, act);
            end
            for (int unsigned k = 0; k < 4; k++) begin
                if (act[k]) begin
                    pcount[k]++;
                    plast[k] = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int unsigned k = 0; k < 4; k++) begin
            pcount[k] = 0;
            plast[k]  = -1;
        end
    endtask

    // Literal expectation: pulse count of output idx and cycle of its last pulse.
    task automatic check_pulse(input string name, input int idx, input int ecount, input int elast);
        checks++;
        if (pcount[idx] != ecount || (ecount > 0 && plast[idx] != elast)) begin
            errors++;
            $display("FAIL %s actual count=%0d last=%0d required count=%0d last=%0d",
                     name, pcount[idx], plast[idx], ecount, elast);
        end
    endtask

    int n_edge;

    initial begin
        clear_counts();
        // 1: reset with all buttons held
        tick(3);
        check_pulse("t1_reset_set", 0, 0, 0);
        check_pulse("t1_reset_sw", 1, 0, 0);
        check_pulse("t1_reset_long", 2, 0, 0);
        check_pulse("t1_reset_short", 3, 0, 0);
        rst = 1'b0;
        n_edge = cyc + 1;
        tick(10);
        check_pulse("t1_set", 0, 1, n_edge + 7);
        check_pulse("t1_sw", 1, 1, n_edge + 8);
        check_pulse("t1_no_inc_short", 3, 0, 0);
        btn_inc_raw = 1'b0;
        btn_set_raw = 1'b0;
        btn_sw_raw  = 1'b0;
        n_edge = cyc + 1;
        tick(12);
        check_pulse("t1_inc_short", 3, 1, n_edge + 7);
        check_pulse("t1_no_long", 2, 0, 0);

        // 2: bouncing SET, then held
        clear_counts();
        for (int unsigned i = 0; i < 12; i++) begin
            btn_set_raw = ((i / 2) % 2 == 0);
            tick(1);
        end
        btn_set_raw = 1'b1;
        n_edge = cyc + 1;
        tick(12);
        check_pulse("t2_set", 0, 1, n_edge + 7);
        check_pulse("t2_no_sw", 1, 0, 0);
        check_pulse("t2_no_short", 3, 0, 0);
        btn_set_raw = 1'b0;
        tick(12);
        check_pulse("t2_no_set_on_release", 0, 1, n_edge + 7);

        // 3: short INC press
        clear_counts();
        btn_inc_raw = 1'b1;
        tick(10);
        btn_inc_raw = 1'b0;
        n_edge = cyc + 1;
        tick(12);
        check_pulse("t3_short", 3, 1, n_edge + 7);
        check_pulse("t3_no_long", 2, 0, 0);

        // 4: long INC press
        clear_counts();
        btn_inc_raw = 1'b1;
        n_edge = cyc + 1;
        tick(60);
        check_pulse("t4_long", 2, 1, n_edge + 27);
        check_pulse("t4_no_short_held", 3, 0, 0);
        btn_inc_raw = 1'b0;
        tick(12);
        check_pulse("t4_no_short_release", 3, 0, 0);
        check_pulse("t4_long_once", 2, 1, n_edge + 27);

        // 5: SET and SW together
        clear_counts();
        btn_set_raw = 1'b1;
        btn_sw_raw  = 1'b1;
        n_edge = cyc + 1;
        tick(12);
        check_pulse("t5_set", 0, 1, n_edge + 7);
        check_pulse("t5_sw", 1, 1, n_edge + 8);
        btn_set_raw = 1'b0;
        btn_sw_raw  = 1'b0;
        tick(12);

        // 6: reset in the middle of an INC press
        clear_counts();
        btn_inc_raw = 1'b1;
        tick(21);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_edge = cyc + 1;
        tick(8);
        btn_inc_raw = 1'b0;
        tick(14);
        check_pulse("t6_short", 3, 1, n_edge + 15);
        check_pulse("t6_no_long", 2, 0, 0);

        // Randomised bouncing buttons with occasional reset
        for (int unsigned i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0)  btn_set_raw = ~btn_set_raw;
            if ($urandom_range(0, 7) == 0)  btn_sw_raw  = ~btn_sw_raw;
            if ($urandom_range(0, 39) == 0) btn_inc_raw = ~btn_inc_raw;
            tick(1);
        end
        rst = 1'b0;
        btn_inc_raw = 1'b0;
        btn_set_raw = 1'b0;
        btn_sw_raw  = 1'b0;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
